pattern_seq_gen: RTL and testbench

Parametrised serial pattern generator: captures a parallel pattern of up to WIDTH bits and streams a programmable-length field of it onto a single serial output, one bit per DIV clock cycles. It supports one-shot or continuous-repeat modes, MSB-first or LSB-first ordering, and start/stop control with busy and done status. It sits in the same single-clock lab designs as the fixed pattern generators, driving LEDs or downstream detector blocks from one serial line.

---
 rtl/pattern_seq_gen.sv | 153 +++++++++++++++
 tb/tb_pattern_seq_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/pattern_seq_gen.sv
// pattern_seq_gen
//   Serial pattern generator. Captures a parallel pattern with a field length
//   and ordering, then streams pattern[L-1:0] onto `out`. Each bit is held for
//   DIV clocks. The generator can run one pass or repeat continuously.
//
// Ports
//   clck         clock, rising edge
//   rst_n        asynchronous active-low reset
//   load         capture pattern/len/lsb_first/repeat_mode (IDLE or ARMED only)
//   pattern      parallel pattern, WIDTH bits
//   len          field length; 0 or >WIDTH is stored as WIDTH
//   lsb_first    1: bit 0 first, 0: bit L-1 first
//   repeat_mode  1: continuous, 0: one-shot
//   start        begin streaming (ARMED only)
//   stop         abort, highest priority
//   out          registered serial data
//   busy         high while streaming
//   done         one-cycle pulse at the end of each complete pass
//   bit_idx      transmission position of the bit on `out`, 0 when idle
module pattern_seq_gen #(
  parameter int WIDTH = 8,
  parameter int DIV   = 1,
  localparam int LW   = $clog2(WIDTH + 1)
) (
  input  logic             clck,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] pattern,
  input  logic [LW-1:0]    len,
  input  logic             lsb_first,
  input  logic             repeat_mode,
  input  logic             start,
  input  logic             stop,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic [LW-1:0]    bit_idx
);

  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ARMED,
    S_RUN
  } state_e;

  state_e           state_q;
  logic [WIDTH-1:0] pat_q;
  logic [LW-1:0]    len_q;
  logic             lsb_q;
  logic             rep_q;
  logic             loaded_q;
  logic [DW-1:0]    div_q;
  logic             out_q;
  logic             busy_q;
  logic             done_q;
  logic [LW-1:0]    idx_q;

  logic [LW-1:0]    len_d;
  logic [LW-1:0]    idx_d;
  logic [LW-1:0]    pos_first;
  logic [LW-1:0]    pos_next;
  logic             last_bit;
  logic             last_div;
  logic             bit_first;
  logic             bit_next;

  always_comb begin
    len_d     = ((len == '0) || (len > LW'(WIDTH))) ? LW'(WIDTH) : len;
    last_div  = (div_q == DW'(DIV - 1));
    last_bit  = (idx_q == len_q - LW'(1));
    // idx_d wraps to 0 at the end of a pass, so bit_next is the first bit
    // again, which is exactly what repeat mode needs for a gapless wrap.
    idx_d     = last_bit ? '0 : idx_q + LW'(1);
    // Map transmission position to pattern bit position.
    pos_first = lsb_q ? '0 : len_q - LW'(1);
    pos_next  = lsb_q ? idx_d : len_q - LW'(1) - idx_d;
    bit_first = |(pat_q & (WIDTH'(1) << pos_first));
    bit_next  = |(pat_q & (WIDTH'(1) << pos_next));
  end

  always_ff @(posedge clck or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      pat_q    <= '0;
      len_q    <= LW'(WIDTH);
      lsb_q    <= 1'b0;
      rep_q    <= 1'b0;
      loaded_q <= 1'b0;
      div_q    <= '0;
      out_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      idx_q    <= '0;
    end else begin
      done_q <= 1'b0;
      if (stop) begin
        state_q <= loaded_q ? S_ARMED : S_IDLE;
        out_q   <= 1'b0;
        busy_q  <= 1'b0;
        idx_q   <= '0;
        div_q   <= '0;
      end else begin
        case (state_q)
          S_IDLE, S_ARMED: begin
            if (load) begin
              pat_q    <= pattern;
              len_q    <= len_d;
              lsb_q    <= lsb_first;
              rep_q    <= repeat_mode;
              loaded_q <= 1'b1;
              state_q  <= S_ARMED;
            end else if (start && (state_q == S_ARMED)) begin
              state_q <= S_RUN;
              busy_q  <= 1'b1;
              out_q   <= bit_first;
              idx_q   <= '0;
              div_q   <= '0;
            end
          end
          S_RUN: begin
            if (!last_div) begin
              div_q <= div_q + DW'(1);
            end else begin
              div_q <= '0;
              idx_q <= idx_d;
              if (last_bit) begin
                done_q <= 1'b1;
                if (rep_q) begin
                  out_q <= bit_next;
                end else begin
                  state_q <= S_ARMED;
                  out_q   <= 1'b0;
                  busy_q  <= 1'b0;
                end
              end else begin
                out_q <= bit_next;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign out     = out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign bit_idx = idx_q;

endmodule

// File: tb/tb_pattern_seq_gen.sv
// Scoreboard bench for pattern_seq_gen. Two instances (DIV=1 and DIV=2) share
// all stimulus; expected streams are written as hand-computed bit strings in
// transmission order and expanded into per-cycle entries for each instance.
module tb_pattern_seq_gen;

  logic       clck = 1'b0;
  logic       rst_n;
  logic       load;
  logic       start;
  logic       stop;
  logic       lsb_first;
  logic       repeat_mode;
  logic [7:0] pattern;
  logic [3:0] len;

  logic       out1, busy1, done1;
  logic [3:0] idx1;
  logic       out2, busy2, done2;
  logic [3:0] idx2;

  always #5 clck = ~clck;

  pattern_seq_gen #(.WIDTH(8), .DIV(1)) u_div1 (
    .clck(clck), .rst_n(rst_n), .load(load), .pattern(pattern), .len(len),
    .lsb_first(lsb_first), .repeat_mode(repeat_mode), .start(start),
    .stop(stop), .out(out1), .busy(busy1), .done(done1), .bit_idx(idx1)
  );

  pattern_seq_gen #(.WIDTH(8), .DIV(2)) u_div2 (
    .clck(clck), .rst_n(rst_n), .load(load), .pattern(pattern), .len(len),
    .lsb_first(lsb_first), .repeat_mode(repeat_mode), .start(start),
    .stop(stop), .out(out2), .busy(busy2), .done(done2), .bit_idx(idx2)
  );

  // {out, busy, done, bit_idx}
  typedef struct packed {
    logic       o;
    logic       b;
    logic       d;
    logic [3:0] idx;
  } exp_t;

  exp_t q1[$];
  exp_t q2[$];
  int   errors = 0;
  int   checks = 0;

  task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitors: every cycle an instance presents busy or done, pop and compare.
  always @(negedge clck) begin : mon1
    exp_t e;
    if (busy1 || done1) begin
      if (q1.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL div1 unexpected output: got %0h expected none at %0t",
                 {out1, busy1, done1, idx1}, $time);
      end else begin
        e = q1.pop_front();
        cmp("div1 stream", 16'({out1, busy1, done1, idx1}), 16'(e));
      end
    end
  end

  always @(negedge clck) begin : mon2
    exp_t e;
    if (busy2 || done2) begin
      if (q2.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL div2 unexpected output: got %0h expected none at %0t",
                 {out2, busy2, done2, idx2}, $time);
      end else begin
        e = q2.pop_front();
        cmp("div2 stream", 16'({out2, busy2, done2, idx2}), 16'(e));
      end
    end
  end

  task automatic tick();
    @(posedge clck);
    #1;
  endtask

  // Expand a bit string (transmission order) into per-cycle entries for both
  // instances. stop_n > 0 truncates to the cycles before the stop edge.
  task automatic expect_run(input string s, input bit rep, input int stop_n);
    for (int d = 1; d <= 2; d++) begin
      int L;
      int pass;
      int total;
      L    = s.len();
      pass = L * d;
      if (rep) begin
        total = stop_n;
      end else begin
        total = pass + 1;
        if (stop_n > 0 && stop_n < total) total = stop_n;
      end
      for (int c = 0; c < total; c++) begin
        exp_t e;
        int   pos;
        if (!rep && c == pass) begin
          e = {1'b0, 1'b0, 1'b1, 4'd0};
        end else begin
          pos = (c / d) % L;
          e = {(s[pos] == "1"), 1'b1, (rep && c > 0 && (c % pass) == 0), 4'(pos)};
        end
        if (d == 1) q1.push_back(e);
        else        q2.push_back(e);
      end
    end
  endtask

  task automatic check_empty(input string name);
    cmp({name, " div1 leftover"}, 16'(q1.size()), 16'd0);
    cmp({name, " div2 leftover"}, 16'(q2.size()), 16'd0);
    q1.delete();
    q2.delete();
  endtask

  task automatic load_cfg(input logic [7:0] p, input logic [3:0] l,
                          input logic lsb, input logic rep);
    pattern     = p;
    len         = l;
    lsb_first   = lsb;
    repeat_mode = rep;
    load        = 1'b1;
    tick();
    load        = 1'b0;
  endtask

  task automatic run(input string name, input string s, input bit rep, input int stop_n);
    expect_run(s, rep, stop_n);
    start = 1'b1;
    tick();
    start = 1'b0;
    if (stop_n > 0) begin
      repeat (stop_n - 1) tick();
      stop = 1'b1;
      tick();
      stop = 1'b0;
      repeat (3) tick();
    end else begin
      repeat (2 * s.len() + 4) tick();
    end
    check_empty(name);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; load = 1'b0; start = 1'b0; stop = 1'b0;
    lsb_first = 1'b0; repeat_mode = 1'b0; pattern = '0; len = '0;
    repeat (2) tick();
    cmp("reset div1", 16'({out1, busy1, done1, idx1}), 16'd0);
    cmp("reset div2", 16'({out2, busy2, done2, idx2}), 16'd0);
    rst_n = 1'b1;
    tick();

    // start while IDLE is ignored
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    cmp("idle start busy", 16'({busy1, busy2}), 16'd0);
    check_empty("idle start");

    load_cfg(8'hB5, 4'd8, 1'b0, 1'b0);
    run("msb full", "10110101", 1'b0, 0);

    load_cfg(8'hB5, 4'd4, 1'b0, 1'b0);
    run("msb len4", "0101", 1'b0, 0);
    load_cfg(8'hB5, 4'd4, 1'b1, 1'b0);
    run("lsb len4", "1010", 1'b0, 0);

    load_cfg(8'hB5, 4'd3, 1'b0, 1'b1);
    run("repeat len3", "101", 1'b1, 14);

    load_cfg(8'hB5, 4'd0, 1'b0, 1'b0);
    run("len0 clamp", "10110101", 1'b0, 0);
    load_cfg(8'hB5, 4'd15, 1'b1, 1'b0);
    run("len15 clamp", "10101101", 1'b0, 0);

    // stop on the 3rd bit, then replay from bit 0
    load_cfg(8'hB5, 4'd8, 1'b0, 1'b0);
    run("stop 3rd bit", "10110101", 1'b0, 3);
    run("replay", "10110101", 1'b0, 0);

    // stop on the pass-end edge: DIV=2 at cycle 16, DIV=1 at cycle 8
    run("stop end div2", "10110101", 1'b0, 16);
    run("stop end div1", "10110101", 1'b0, 8);

    // load and start together in ARMED: load wins, start ignored
    pattern = 8'hB5; len = 4'd2; lsb_first = 1'b1; repeat_mode = 1'b0;
    load = 1'b1; start = 1'b1;
    tick();
    load = 1'b0; start = 1'b0;
    repeat (3) tick();
    cmp("load+start busy", 16'({busy1, busy2}), 16'd0);
    check_empty("load+start");
    run("after load+start", "10", 1'b0, 0);

    // load during RUN is ignored, both now and for the next pass
    load_cfg(8'hB5, 4'd8, 1'b0, 1'b0);
    expect_run("10110101", 1'b0, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    pattern = 8'h00; len = 4'd2; lsb_first = 1'b1; load = 1'b1;
    tick();
    load = 1'b0;
    repeat (20) tick();
    check_empty("load in run");
    run("config kept", "10110101", 1'b0, 0);

    // asynchronous reset mid-stream
    load_cfg(8'hB5, 4'd8, 1'b0, 1'b0);
    start = 1'b1;
    tick();
    start = 1'b0;
    cmp("pre-reset out/busy", 16'({out1, busy1, out2, busy2}), 16'hF);
    #1 rst_n = 1'b0;
    #1 cmp("async reset outputs",
           16'({out1, busy1, done1, idx1, out2, busy2, done2, idx2}), 16'd0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) tick();
    cmp("start after reset busy", 16'({busy1, busy2}), 16'd0);
    check_empty("start after reset");
    load_cfg(8'hB5, 4'd4, 1'b1, 1'b0);
    run("after reset reload", "1010", 1'b0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
